uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small transmit FIFO.
// Writes are taken on a rising edge of the software-held tx_wr level.
// Frames are sent back-to-back while the FIFO holds data.
// The line output comes straight from a flop.
module uart_tx #(
  parameter int freq_hz    = 25000000,
  parameter int baud       = 115200,
  parameter int fifo_depth = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_full,
  output logic       tx_overrun
);

  localparam int DIV = freq_hz / baud;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(fifo_depth);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(fifo_depth);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_pending;
  logic          r_wr_prev;
  logic          r_wr_armed;
  logic          r_overrun;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_mem [fifo_depth];

  logic       w_wr_rise;
  logic       w_empty;
  logic       w_full;
  logic       w_baud_end;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [2:0] w_bit_next;

  // r_wr_armed stays low after reset until tx_wr has been seen low,
  // so a level already high at reset release is not taken as a new write.
  assign w_wr_rise  = tx_wr & ~r_wr_prev & r_wr_armed;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH);
  assign w_baud_end = (r_cnt == CNT_LAST);
  // Pop either from IDLE (one cycle before START) or at the final
  // clock of STOP, so consecutive frames have no idle gap between them.
  assign w_pop      = ~w_empty & (((r_state == S_IDLE) & ~r_pending) |
                                  ((r_state == S_STOP) & w_baud_end));
  // A pop in the same cycle frees a slot, so a write is accepted
  // even when the FIFO is currently full.
  assign w_push     = w_wr_rise & (~w_full | w_pop);
  assign w_drop     = w_wr_rise & ~w_push;
  assign w_bit_next = r_bit + 3'd1;

  assign uart_txd   = r_txd;
  assign tx_busy    = (r_state != S_IDLE) | r_pending | ~w_empty;
  assign tx_full    = w_full;
  assign tx_overrun = r_overrun;

  // Sample tx_wr for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_prev  <= 1'b0;
      r_wr_armed <= 1'b0;
    end else begin
      r_wr_prev <= tx_wr;
      if (!tx_wr) r_wr_armed <= 1'b1;
    end
  end

  // FIFO storage: write port only, with no reset, so it can map to RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy, plus the dropped-write pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      r_overrun <= w_drop;
    end
  end

  // Frame sequencer; r_txd is loaded with the level for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (r_pending) begin
            r_state   <= S_START;
            r_cnt     <= '0;
            r_txd     <= 1'b0;
            r_pending <= 1'b0;
          end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_pending <= 1'b1;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_txd   <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit <= w_bit_next;
              r_txd <= r_shift[w_bit_next];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
// Instance A uses the default parameters (217 clocks per bit).
// Instance B runs 4 clocks per bit.
// Expected line levels are hand-written 10-bit frames; bit k is line slot k.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] wr;
  logic [7:0] data [2];
  logic a_txd, a_busy, a_full, a_ovr;
  logic b_txd, b_busy, b_full, b_ovr;
  wire [1:0] txd  = {b_txd,  a_txd};
  wire [1:0] busy = {b_busy, a_busy};
  wire [1:0] full = {b_full, a_full};
  wire [1:0] ovr  = {b_ovr,  a_ovr};

  uart_tx u_a (
    .clk(clk), .reset(rst[0]), .tx_data(data[0]), .tx_wr(wr[0]),
    .uart_txd(a_txd), .tx_busy(a_busy), .tx_full(a_full), .tx_overrun(a_ovr)
  );

  uart_tx #(.freq_hz(1000000), .baud(250000)) u_b (
    .clk(clk), .reset(rst[1]), .tx_data(data[1]), .tx_wr(wr[1]),
    .uart_txd(b_txd), .tx_busy(b_busy), .tx_full(b_full), .tx_overrun(b_ovr)
  );

  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
  } vec_t;

  vec_t tbl [6];
  vec_t seq_b [6];
  vec_t seq_a [5];

  int vec_cnt  = 0;
  int miss_cnt = 0;

  function automatic int divof(input int s);
    return (s == 1) ? 4 : 217;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Called just before the posedge on which the start bit begins.
  // Every clock of the frame is compared; the mid-slot samples are reported.
  task automatic check_frame(input int s, input logic [9:0] exp, input string name);
    int div = divof(s);
    int bad = 0;
    logic [9:0] act = '0;
    for (int j = 0; j < 10 * div; j++) begin
      @(negedge clk);
      if (txd[s] !== exp[j / div]) bad++;
      if (busy[s] !== 1'b1) bad++;
      if ((j % div) == (div / 2)) act[j / div] = txd[s];
    end
    vec_cnt++;
    if (bad != 0 || act !== exp) begin
      miss_cnt++;
      $display("FAIL frame_%s: got %h expected %h (%0d bad clocks)", name, act, exp, bad);
    end else begin
      $display("ok   frame_%s = %h", name, act);
    end
  endtask

  // Raise tx_wr at a negedge; returns just after the enqueue edge.
  // tx_data is then scrambled to show the queued byte is already captured.
  task automatic enqueue(input int s, input logic [7:0] d, input bit hold);
    data[s] = d;
    wr[s]   = 1'b1;
    @(negedge clk);
    if (!hold) wr[s] = 1'b0;
    data[s] = ~d;
  endtask

  task automatic send_frame(input int s, input logic [7:0] d, input logic [9:0] f,
                            input string name, input bit hold);
    enqueue(s, d, hold);
    @(negedge clk);
    chk({name, "_pre_start_high"}, 32'(txd[s]), 32'd1);
    check_frame(s, f, name);
    @(negedge clk);
    chk({name, "_busy_fall"}, 32'(busy[s]), 32'd0);
  endtask

  initial begin
    int cnt;

    tbl[0] = '{8'h55, 10'h2AA};
    tbl[1] = '{8'h80, 10'h300};
    tbl[2] = '{8'hA3, 10'h346};
    tbl[3] = '{8'h00, 10'h200};
    tbl[4] = '{8'hFF, 10'h3FE};
    tbl[5] = '{8'h01, 10'h202};

    seq_b[0] = '{8'h11, 10'h222};
    seq_b[1] = '{8'h22, 10'h244};
    seq_b[2] = '{8'h33, 10'h266};
    seq_b[3] = '{8'h44, 10'h288};
    seq_b[4] = '{8'h55, 10'h2AA};
    seq_b[5] = '{8'h66, 10'h2CC};

    seq_a[0] = '{8'h01, 10'h202};
    seq_a[1] = '{8'h02, 10'h204};
    seq_a[2] = '{8'h03, 10'h206};
    seq_a[3] = '{8'h04, 10'h208};
    seq_a[4] = '{8'h05, 10'h20A};

    rst     = 2'b11;
    wr      = 2'b00;
    data[0] = 8'h00;
    data[1] = 8'h00;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_txd", s),  32'(txd[s]),  32'd1);
      chk($sformatf("rst%0d_busy", s), 32'(busy[s]), 32'd0);
      chk($sformatf("rst%0d_full", s), 32'(full[s]), 32'd0);
      chk($sformatf("rst%0d_ovr", s),  32'(ovr[s]),  32'd0);
    end
    rst = 2'b00;
    repeat (2) @(negedge clk);

    // Table of single frames at 4 clocks per bit.
    for (int i = 0; i < 6; i++)
      send_frame(1, tbl[i].d, tbl[i].f, $sformatf("b_v%0d", i), 1'b0);

    // Fill B, then write on the exact edge where the first STOP ends (pop + push).
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          enqueue(1, seq_b[k].d, 1'b0);
          @(negedge clk);
        end
        chk("b_full_after_5", 32'(full[1]), 32'd1);
        repeat (32) @(negedge clk);
        chk("b_full_before_simul", 32'(full[1]), 32'd1);
        enqueue(1, seq_b[5].d, 1'b0);
        chk("b_simul_ovr", 32'(ovr[1]), 32'd0);
        chk("b_simul_full", 32'(full[1]), 32'd1);
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++)
          check_frame(1, seq_b[k].f, $sformatf("b_simul%0d", k));
        @(negedge clk);
        chk("b_simul_busy_fall", 32'(busy[1]), 32'd0);
      end
    join

    // tx_wr high through reset release must not enqueue.
    rst[1]  = 1'b1;
    wr[1]   = 1'b1;
    data[1] = 8'h3C;
    repeat (3) @(negedge clk);
    rst[1] = 1'b0;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (busy[1] !== 1'b0 || txd[1] !== 1'b1) cnt++;
    end
    chk("b_wr_high_at_release", 32'(cnt), 32'd0);
    wr[1] = 1'b0;
    @(negedge clk);
    send_frame(1, 8'h3C, 10'h278, "b_after_release", 1'b0);

    // Default-rate single frame.
    send_frame(0, 8'h55, 10'h2AA, "a55", 1'b0);

    // Held tx_wr: one frame only.
    send_frame(0, 8'hA3, 10'h346, "aA3_hold", 1'b1);
    cnt = 0;
    for (int j = 0; j < 2827; j++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) cnt++;
    end
    chk("a_hold_no_restart", 32'(cnt), 32'd0);
    wr[0] = 1'b0;
    @(negedge clk);

    // Five back-to-back writes, then a dropped write while full.
    fork
      begin
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
          enqueue(0, seq_a[k].d, 1'b0);
          if (ovr[0] !== 1'b0) cnt++;
          @(negedge clk);
          if (ovr[0] !== 1'b0) cnt++;
        end
        chk("a_no_overrun_fill", 32'(cnt), 32'd0);
        chk("a_full_after_5", 32'(full[0]), 32'd1);
        enqueue(0, 8'hFF, 1'b0);
        chk("a_overrun_pulse", 32'(ovr[0]), 32'd1);
        @(negedge clk);
        chk("a_overrun_one_cycle", 32'(ovr[0]), 32'd0);
        chk("a_full_after_drop", 32'(full[0]), 32'd1);
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++)
          check_frame(0, seq_a[k].f, $sformatf("a_b2b%0d", k));
        @(negedge clk);
        chk("a_b2b_busy_fall", 32'(busy[0]), 32'd0);
      end
    join

    // Reset 1000 clocks into a 0x00 frame with two bytes queued behind it.
    enqueue(0, 8'h00, 1'b0);
    @(negedge clk);
    enqueue(0, 8'h77, 1'b0);
    @(negedge clk);
    enqueue(0, 8'h78, 1'b0);
    repeat (997) @(negedge clk);
    chk("a_mid_frame_low", 32'(txd[0]), 32'd0);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("a_abort_txd", 32'(txd[0]), 32'd1);
    chk("a_abort_busy", 32'(busy[0]), 32'd0);
    chk("a_abort_full", 32'(full[0]), 32'd0);
    rst[0] = 1'b0;
    cnt = 0;
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) cnt++;
    end
    chk("a_queue_discarded", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
